// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: line-granular PC sequencer feeding a multi-write,
// multi-read instruction queue whose entries carry their own PC.
module ifu_fetch_queue #(
   parameter int ADDR_W  = 48,
   parameter int LINE_W  = 512,
   parameter int INST_W  = 32,
   parameter int INDEX_W = 19,
   parameter int DEPTH   = 32,
   parameter int DEQ_W   = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [ADDR_W-1:0]             boot_addr,
   input  logic                          interrupt_valid,
   input  logic [ADDR_W-1:0]             interrupt_addr,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_target,
   input  logic                          flush_ext,
   output logic                          req_valid,
   input  logic                          req_ready,
   output logic [INDEX_W-1:0]            req_index,
   input  logic                          rsp_valid,
   input  logic [LINE_W-1:0]             rsp_data,
   output logic [DEQ_W-1:0]              out_valid,
   output logic [DEQ_W*INST_W-1:0]       out_inst,
   output logic [DEQ_W*ADDR_W-1:0]       out_pc,
   input  logic [$clog2(DEQ_W+1)-1:0]    deq_count,
   output logic                          fifo_empty,
   output logic [$clog2(DEPTH):0]        fifo_count,
   output logic [1:0]                    fsm_state
);

   localparam int SLOTS  = LINE_W / INST_W;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int IB_W   = $clog2(INST_W / 8);
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int AW     = $clog2(DEPTH);
   localparam int PTR_W  = AW + 1;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_KILL = 2'd3;

   logic [1:0]          state, state_nxt;
   logic [ADDR_W-1:0]   pc, pc_nxt;
   logic [ADDR_W-1:0]   line_base;
   logic [ADDR_W-1:0]   redir_pc;
   logic                redir;
   logic [SLOT_W-1:0]   first_slot;
   logic [SLOT_W:0]     enq_n;
   logic                space_ok;
   logic                enq;
   logic [PTR_W-1:0]    head, tail;
   logic [INST_W-1:0]   mem_inst [DEPTH];
   logic [ADDR_W-1:0]   mem_pc   [DEPTH];
   logic [AW-1:0]       wr_addr  [SLOTS];
   logic [SLOTS-1:0]    wr_en;

   assign redir      = interrupt_valid | redirect_valid | flush_ext;
   assign redir_pc   = interrupt_valid ? interrupt_addr :
                       redirect_valid  ? redirect_target : pc;
   assign line_base  = {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign first_slot = pc[OFF_W-1:IB_W];
   assign enq_n      = (SLOT_W+1)'(SLOTS) - {1'b0, first_slot};

   assign fifo_count = tail - head;
   assign fifo_empty = (fifo_count == '0);
   // Free space is judged on the current count only; a same-cycle dequeue earns no credit.
   assign space_ok   = (PTR_W'(DEPTH) - fifo_count) >= PTR_W'(enq_n);

   // Request channel: a line request transfers on a cycle where req_valid && req_ready
   // at the rising edge; req_valid is dropped combinationally during any redirect, and
   // req_index is held from the pc register for as long as req_valid stays high.
   assign req_valid  = (state == S_REQ) && space_ok && !redir;
   assign req_index  = pc[OFF_W+INDEX_W-1:OFF_W];
   assign enq        = (state == S_WAIT) && rsp_valid && !redir;
   assign fsm_state  = state;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         S_BOOT: begin
            state_nxt = S_REQ;
            pc_nxt    = boot_addr;
         end
         S_REQ: begin
            if (redir) begin
               pc_nxt = redir_pc;
            end else if (req_ready && req_valid) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redir) begin
               pc_nxt    = redir_pc;
               state_nxt = rsp_valid ? S_REQ : S_KILL;
            end else if (rsp_valid) begin
               pc_nxt    = line_base + ADDR_W'(LINE_W / 8);
               state_nxt = S_REQ;
            end
         end
         default: begin
            // KILL: the outstanding response is stale and is dropped on arrival.
            if (redir) begin
               pc_nxt = redir_pc;
            end
            if (rsp_valid) begin
               state_nxt = S_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_BOOT;
         pc    <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (redir) begin
            head <= '0;
            tail <= '0;
         end else begin
            head <= head + PTR_W'(deq_count);
            if (enq) begin
               tail <= tail + PTR_W'(enq_n);
            end
         end
      end
   end

   // Slot i of the line lands at tail + (i - first_slot), preserving program order.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         wr_en[i]   = enq && (SLOT_W'(i) >= first_slot);
         wr_addr[i] = tail[AW-1:0] + AW'(i) - AW'(first_slot);
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < SLOTS; i++) begin
         if (wr_en[i]) begin
            mem_inst[wr_addr[i]] <= rsp_data[i*INST_W +: INST_W];
            mem_pc[wr_addr[i]]   <= line_base + ADDR_W'(i * (INST_W / 8));
         end
      end
   end

   always_comb begin
      for (int k = 0; k < DEQ_W; k++) begin
         out_valid[k]                  = fifo_count > PTR_W'(k);
         out_inst[k*INST_W +: INST_W]  = mem_inst[head[AW-1:0] + AW'(k)];
         out_pc[k*ADDR_W +: ADDR_W]    = mem_pc[head[AW-1:0] + AW'(k)];
      end
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: memory responder, redirect vector table and a
// scoreboard of {pc, inst} entries expected at the queue head.
module tb_ifu_fetch_queue;

   localparam int ADDR_W  = 48;
   localparam int LINE_W  = 512;
   localparam int INST_W  = 32;
   localparam int INDEX_W = 19;
   localparam int DEPTH   = 32;
   localparam int DEQ_W   = 2;
   localparam int SLOTS   = 16;
   localparam int E_W     = ADDR_W + INST_W;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_KILL = 2'd3;

   logic                      clock = 1'b0;
   logic                      reset_n;
   logic [ADDR_W-1:0]         boot_addr;
   logic                      interrupt_valid;
   logic [ADDR_W-1:0]         interrupt_addr;
   logic                      redirect_valid;
   logic [ADDR_W-1:0]         redirect_target;
   logic                      flush_ext;
   logic                      req_valid;
   logic                      req_ready;
   logic [INDEX_W-1:0]        req_index;
   logic                      rsp_valid;
   logic [LINE_W-1:0]         rsp_data;
   logic [DEQ_W-1:0]          out_valid;
   logic [DEQ_W*INST_W-1:0]   out_inst;
   logic [DEQ_W*ADDR_W-1:0]   out_pc;
   logic [1:0]                deq_count;
   logic                      fifo_empty;
   logic [5:0]                fifo_count;
   logic [1:0]                fsm_state;

   logic [E_W-1:0]            exp_q[$];
   logic [ADDR_W-1:0]         model_pc;
   int                        total = 0;
   int                        bad = 0;

   typedef struct {
      logic              iv;
      logic [ADDR_W-1:0] ia;
      logic              rv;
      logic [ADDR_W-1:0] rt;
      logic              fl;
      logic [ADDR_W-1:0] exp_pc;
      int                exp_n;
      logic [18:0]       exp_idx;
   } redir_vec_t;

   redir_vec_t vecs[5];

   ifu_fetch_queue dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .boot_addr       (boot_addr),
      .interrupt_valid (interrupt_valid),
      .interrupt_addr  (interrupt_addr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .flush_ext       (flush_ext),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_index       (req_index),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .out_valid       (out_valid),
      .out_inst        (out_inst),
      .out_pc          (out_pc),
      .deq_count       (deq_count),
      .fifo_empty      (fifo_empty),
      .fifo_count      (fifo_count),
      .fsm_state       (fsm_state)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [INST_W-1:0] word_of(input logic [18:0] idx, input int slot);
      return {8'h5A, 4'(slot), 1'b0, idx};
   endfunction

   function automatic logic [LINE_W-1:0] line_of(input logic [18:0] idx);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < SLOTS; i++) l[i*INST_W +: INST_W] = word_of(idx, i);
      return l;
   endfunction

   task automatic compare_head(input string nm);
      int n;
      logic [E_W-1:0] e;
      n = exp_q.size();
      check({nm, "_count"}, 64'(fifo_count), 64'(n));
      for (int k = 0; k < DEQ_W; k++) begin
         check({nm, "_valid"}, 64'(out_valid[k]), 64'(k < n));
         if (k < n) begin
            e = exp_q[k];
            check({nm, "_pc"}, 64'(out_pc[k*ADDR_W +: ADDR_W]), 64'(e[E_W-1:INST_W]));
            check({nm, "_inst"}, 64'(out_inst[k*INST_W +: INST_W]), 64'(e[INST_W-1:0]));
         end
      end
   endtask

   // Request the line at model_pc, answer after lat cycles, optionally dequeue on the enqueue cycle.
   task automatic fetch_line(input int lat, input int deq_k);
      int waited;
      int k;
      logic [18:0] idx;
      logic [ADDR_W-1:0] base;
      waited = 0;
      idx = model_pc[24:6];
      base = {model_pc[ADDR_W-1:6], 6'b0};
      req_ready = 1'b1;
      @(negedge clock);
      while (!req_valid && waited < 60) begin
         @(negedge clock);
         waited++;
      end
      check("req_valid_wait", 64'(req_valid), 64'd1);
      check("req_index", 64'(req_index), 64'(idx));
      @(posedge clock); #1;
      req_ready = 1'b0;
      check("state_wait", 64'(fsm_state), 64'(S_WAIT));
      repeat (lat) begin
         @(posedge clock); #1;
      end
      compare_head("pre_enq");
      k = (deq_k > exp_q.size()) ? exp_q.size() : deq_k;
      deq_count = 2'(k);
      rsp_valid = 1'b1;
      rsp_data = line_of(idx);
      @(posedge clock); #1;
      rsp_valid = 1'b0;
      deq_count = '0;
      repeat (k) void'(exp_q.pop_front());
      for (int s = int'(model_pc[5:2]); s < SLOTS; s++)
         exp_q.push_back({base + 48'(s * 4), word_of(idx, s)});
      model_pc = base + 48'd64;
      compare_head("post_enq");
   endtask

   task automatic drain_until(input int limit, input bit rnd);
      int guard;
      int k;
      guard = 0;
      while (exp_q.size() > limit && guard < 400) begin
         @(negedge clock);
         compare_head("drain");
         k = rnd ? int'($urandom_range(0, DEQ_W)) : DEQ_W;
         if (k > exp_q.size()) k = exp_q.size();
         deq_count = 2'(k);
         @(posedge clock); #1;
         deq_count = '0;
         repeat (k) void'(exp_q.pop_front());
         guard++;
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 48'h0,    1'b1, 48'h2038, 1'b0, 48'h2038, 2,  19'h80};
      vecs[1] = '{1'b1, 48'h8000, 1'b1, 48'h4000, 1'b0, 48'h8000, 16, 19'h200};
      vecs[2] = '{1'b0, 48'h0,    1'b0, 48'h0,    1'b1, 48'h8040, 16, 19'h201};
      vecs[3] = '{1'b1, 48'h123C, 1'b0, 48'h0,    1'b0, 48'h123C, 1,  19'h48};
      vecs[4] = '{1'b0, 48'h0,    1'b1, 48'h5004, 1'b1, 48'h5004, 15, 19'h140};

      reset_n = 1'b0;
      boot_addr = 48'h1000;
      interrupt_valid = 1'b0;
      interrupt_addr = '0;
      redirect_valid = 1'b0;
      redirect_target = '0;
      flush_ext = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data = '0;
      deq_count = '0;
      model_pc = 48'h1000;

      // Reset values and boot sequence
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_empty", 64'(fifo_empty), 64'd1);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_state", 64'(fsm_state), 64'(S_BOOT));
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("boot_req_valid", 64'(req_valid), 64'd0);
      check("boot_state", 64'(fsm_state), 64'(S_BOOT));
      @(posedge clock); #1;
      check("boot_req_state", 64'(fsm_state), 64'(S_REQ));
      check("boot_req_valid2", 64'(req_valid), 64'd1);
      check("boot_req_index", 64'(req_index), 64'h40);
      fetch_line(0, 0);
      check("boot_count16", 64'(fifo_count), 64'd16);
      check("boot_pc0", 64'(out_pc[ADDR_W-1:0]), 64'h1000);
      check("boot_pc1", 64'(out_pc[2*ADDR_W-1:ADDR_W]), 64'h1004);
      fetch_line(2, 0);

      // Backpressure: full queue withholds requests until a full line fits again
      for (int i = 0; i <= 8; i++) begin
         @(negedge clock);
         compare_head("bp");
         check("bp_req_valid", 64'(req_valid), 64'((DEPTH - exp_q.size()) >= 16));
         if (i < 8) begin
            deq_count = 2'd2;
            @(posedge clock); #1;
            deq_count = '0;
            repeat (2) void'(exp_q.pop_front());
         end
      end
      check("bp_full_count", 64'(fifo_count), 64'd16);
      @(posedge clock); #1;
      drain_until(0, 1'b1);

      // Redirect vectors applied in REQ; each clears whatever the previous one left queued
      for (int v = 0; v < 5; v++) begin
         int k;
         k = (exp_q.size() < 2) ? exp_q.size() : 2;
         interrupt_valid = vecs[v].iv;
         interrupt_addr = vecs[v].ia;
         redirect_valid = vecs[v].rv;
         redirect_target = vecs[v].rt;
         flush_ext = vecs[v].fl;
         deq_count = 2'(k);
         req_ready = 1'b1;
         @(negedge clock);
         check("redir_gate", 64'(req_valid), 64'd0);
         @(posedge clock); #1;
         interrupt_valid = 1'b0;
         redirect_valid = 1'b0;
         flush_ext = 1'b0;
         deq_count = '0;
         req_ready = 1'b0;
         exp_q.delete();
         model_pc = vecs[v].exp_pc;
         check("redir_cleared", 64'(fifo_count), 64'd0);
         check("redir_empty", 64'(fifo_empty), 64'd1);
         check("redir_state", 64'(fsm_state), 64'(S_REQ));
         check("redir_idx", 64'(req_index), 64'(vecs[v].exp_idx));
         fetch_line(v, 0);
         check("redir_n", 64'(fifo_count), 64'(vecs[v].exp_n));
         check("redir_next_idx", 64'(req_index), 64'(vecs[v].exp_idx) + 64'd1);
      end
      drain_until(0, 1'b1);

      // Kill: redirect while a request is outstanding, stale line must be dropped
      fetch_line(0, 0);
      req_ready = 1'b1;
      @(negedge clock);
      check("kill_req_valid", 64'(req_valid), 64'd1);
      @(posedge clock); #1;
      req_ready = 1'b0;
      check("kill_in_wait", 64'(fsm_state), 64'(S_WAIT));
      redirect_valid = 1'b1;
      redirect_target = 48'h3000;
      @(negedge clock);
      check("kill_gate", 64'(req_valid), 64'd0);
      @(posedge clock); #1;
      redirect_valid = 1'b0;
      exp_q.delete();
      model_pc = 48'h3000;
      check("kill_state", 64'(fsm_state), 64'(S_KILL));
      check("kill_cleared", 64'(fifo_count), 64'd0);
      repeat (2) begin
         @(negedge clock);
         check("kill_no_req", 64'(req_valid), 64'd0);
      end
      @(posedge clock); #1;
      rsp_valid = 1'b1;
      rsp_data = line_of(19'h1);
      @(posedge clock); #1;
      rsp_valid = 1'b0;
      check("kill_dropped", 64'(fifo_count), 64'd0);
      check("kill_back_req", 64'(fsm_state), 64'(S_REQ));
      check("kill_req_again", 64'(req_valid), 64'd1);
      check("kill_new_idx", 64'(req_index), 64'hC0);
      fetch_line(1, 0);

      // Many lines through the queue: pointers wrap, order and PCs must hold
      for (int i = 0; i < 12; i++) begin
         fetch_line(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         drain_until(int'($urandom_range(0, 16)), 1'b1);
      end
      drain_until(0, 1'b1);

      // Reset in the middle of an outstanding request
      req_ready = 1'b1;
      @(negedge clock);
      check("mid_req_valid", 64'(req_valid), 64'd1);
      @(posedge clock); #1;
      req_ready = 1'b0;
      check("mid_in_wait", 64'(fsm_state), 64'(S_WAIT));
      reset_n = 1'b0;
      exp_q.delete();
      model_pc = 48'h1000;
      #1;
      check("mid_rst_req_valid", 64'(req_valid), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_empty", 64'(fifo_empty), 64'd1);
      check("mid_rst_count", 64'(fifo_count), 64'd0);
      check("mid_rst_state", 64'(fsm_state), 64'(S_BOOT));
      @(posedge clock); #1;
      rsp_valid = 1'b1;
      rsp_data = line_of(19'h7);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("mid_late_rsp_count", 64'(fifo_count), 64'd0);
      check("mid_restart_state", 64'(fsm_state), 64'(S_REQ));
      check("mid_restart_idx", 64'(req_index), 64'h40);
      @(posedge clock); #1;
      rsp_valid = 1'b0;
      check("mid_late_rsp_count2", 64'(fifo_count), 64'd0);
      fetch_line(1, 0);
      check("mid_head_pc", 64'(out_pc[ADDR_W-1:0]), 64'h1000);
      drain_until(0, 1'b0);
      @(negedge clock);
      check("final_empty", 64'(fifo_empty), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch front end: a line-granular PC sequencer plus a multi-write, multi-read instruction queue. It issues line requests to instruction memory with a valid/ready handshake and unpacks each returned line into per-instruction queue entries, each tagged with its PC. It delivers up to DEQ_W instructions per cycle to decode. Redirects and interrupts are honoured while a request is in flight: the stale response is discarded.

## Interface
- ADDR_W, 48, PC width
- LINE_W, 512, fetch line width in bits (power of 2, multiple of INST_W)
- INST_W, 32, instruction width; SLOTS = LINE_W/INST_W, OFF_W = log2(LINE_W/8)
- INDEX_W, 19, request index width; req_index = pc[OFF_W+INDEX_W-1:OFF_W]
- DEPTH, 32, queue entries (power of 2, >= SLOTS)
- DEQ_W, 2, max instructions dequeued per cycle (1..SLOTS)
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- boot_addr  in  ADDR_W  start PC, static while reset_n low and for one cycle after
- interrupt_valid / interrupt_addr  in  1 / ADDR_W  interrupt redirect, highest priority
- redirect_valid / redirect_target  in  1 / ADDR_W  branch redirect
- flush_ext  in  1  external queue clear, refetch from current pc
- req_valid  out  1  line request valid
- req_ready  in  1  memory accepts request
- req_index  out  INDEX_W  line index of request
- rsp_valid / rsp_data  in  1 / LINE_W  line return, one per accepted request; slot i = rsp_data[i*INST_W +: INST_W]
- out_valid  out  DEQ_W  contiguous-from-bit-0 mask of valid head entries
- out_inst / out_pc  out  DEQ_W*INST_W / DEQ_W*ADDR_W  head entries, slot 0 oldest
- deq_count  in  log2(DEQ_W+1)  entries consumed this cycle, must be <= popcount(out_valid)
- fifo_empty  out  1  queue empty
- fifo_count  out  log2(DEPTH)+1  occupancy

## Operation
- FSM states: BOOT, REQ, WAIT, KILL.
  - BOOT: the only state after reset; pc <= boot_addr; next REQ.
  - REQ: req_valid = space_ok && !redir; on req_valid&&req_ready -> WAIT.
  - WAIT: on rsp_valid enqueue, pc <= {pc[ADDR_W-1:OFF_W]+1, 0} -> REQ.
  - KILL: on rsp_valid drop data -> REQ.
- redir = interrupt_valid || redirect_valid || flush_ext. On redir, pc <= interrupt_addr if interrupt_valid, else redirect_target if redirect_valid, else pc unchanged. Any redir clears the queue.
- State change on redir: WAIT -> KILL; REQ stays REQ; KILL stays KILL.
- Redir with rsp_valid in WAIT or KILL: response dropped, next state REQ, pc updated.
- Enqueue: first slot s = pc[OFF_W-1:log2(INST_W/8)]; slots s..SLOTS-1 written in order, n = SLOTS-s entries. Entry PC = line base + slot*(INST_W/8).
- space_ok = (DEPTH - fifo_count) >= n, evaluated on current count; dequeue in the same cycle is not credited.
- Dequeue: head advances by deq_count. A dequeue coincident with enqueue is applied to both pointers. A dequeue coincident with redir is ignored (queue cleared).
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; overflow is impossible by space_ok.
- Reset values: req_valid=0, out_valid=0, fifo_empty=1, fifo_count=0, state BOOT, pointers 0.

## Timing
- Reset release to first req_valid: 2 cycles (BOOT, then REQ).
- req_index is a register output, stable while req_valid=1 and not redir.
- req_valid is withdrawn in the same cycle as redir (combinational gating). A handshake is possible only when redir=0.
- rsp_valid in WAIT -> entries visible on out_valid the next cycle. Next req_valid is asserted the same cycle if space_ok.
- Redirect to first new-PC request: redirect in REQ gives req_valid next cycle. Redirect in WAIT waits for the old response, then gives req_valid the cycle after.
- deq_count takes effect at the clock edge; out_* update the next cycle.
- rsp_valid outside WAIT/KILL is illegal and ignored.

## Test plan
- Boot: boot_addr=0x1000, req_ready=1 -> req_index=0x40 two cycles after reset release; rsp line -> 16 entries, out_pc 0x1000, 0x1004; next req_index=0x41.
- Partial line: redirect_target=0x2038 in REQ -> req_index=0x80; rsp -> exactly 2 entries, pc 0x2038/0x203C; next req_index=0x81.
- Kill: redirect_target=0x3000 while in WAIT -> queue clears; old rsp dropped (fifo_count stays 0); next req_index=0xC0.
- Priority: interrupt_valid (0x8000) and redirect_valid (0x4000) in the same cycle -> req_index=0x200.
- Backpressure: deq_count=0, fill until count=32 (two full lines) -> req_valid low; dequeue 2/cycle until free >= 16 -> req_valid high. Pointer wrap is exercised over 10+ lines with PC order preserved.
- Reset mid-flight: reset_n low while in WAIT -> all outputs at reset values; late rsp_valid ignored; fetch restarts at boot_addr.
